// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: runs one erase/expose/convert/readout frame on the pixel
// array. During conversion it drives the count onto the shared DATA bus.
// During readout it walks every pixel address, samples the latched code and
// streams it out over a valid/ready handshake.
module pixel_readout_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int ADDR_BITS     = 2,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 erase,
  output logic                 expose,
  output logic                 ramp,
  output logic                 read,
  output logic [ADDR_BITS-1:0] pixel_addr,
  output logic [7:0]           data_out,
  output logic                 data_oe,
  input  logic [7:0]           data_in,
  output logic [7:0]           pix_data,
  output logic [ADDR_BITS-1:0] pix_addr,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CONVERT_CYCLES = 256;
  localparam int MAX_A   = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_B   = (SETTLE_CYCLES > CONVERT_CYCLES) ? SETTLE_CYCLES : CONVERT_CYCLES;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0]     ERASE_LAST   = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     EXPOSE_LAST  = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CONVERT_LAST = CNT_W'(CONVERT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR    = ADDR_BITS'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_TURN,
    S_READ_SETTLE,
    S_READ_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;  // shared phase counter, cleared on every phase entry

  // Frame sequencer: state, phase counter and every registered output.
  // NOTE: clocked logic uses non-blocking assignments only, so each register
  // is computed from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      ramp       <= 1'b0;
      read       <= 1'b0;
      pixel_addr <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      pix_data   <= '0;
      pix_addr   <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ERASE;
            erase <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        S_ERASE: begin
          if (cnt == ERASE_LAST) begin
            state  <= S_EXPOSE;
            erase  <= 1'b0;
            expose <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_EXPOSE: begin
          if (cnt == EXPOSE_LAST) begin
            state    <= S_CONVERT;
            expose   <= 1'b0;
            ramp     <= 1'b1;
            data_oe  <= 1'b1;
            data_out <= '0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // The count on the bus steps once per cycle and never wraps in-phase.
        S_CONVERT: begin
          if (cnt == CONVERT_LAST) begin
            state    <= S_TURN;
            ramp     <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
            cnt      <= '0;
          end else begin
            data_out <= data_out + 8'd1;
            cnt      <= cnt + CNT_W'(1);
          end
        end

        // One idle cycle so the controller releases DATA before pixels drive it.
        S_TURN: begin
          state      <= S_READ_SETTLE;
          read       <= 1'b1;
          pixel_addr <= '0;
          cnt        <= '0;
        end

        S_READ_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state     <= S_READ_HOLD;
            pix_data  <= data_in;
            pix_addr  <= pixel_addr;
            pix_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_READ_HOLD: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pixel_addr != LAST_ADDR) begin
              state      <= S_READ_SETTLE;
              pixel_addr <= pixel_addr + ADDR_BITS'(1);
              cnt        <= '0;
            end else begin
              state      <= S_IDLE;
              read       <= 1'b0;
              pixel_addr <= '0;
              pix_data   <= '0;
              pix_addr   <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              cnt        <= '0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl with a behavioural pixel array
// that latches the conversion count at a per-pixel code and drives it back
// on DATA when addressed.
module tb_pixel_readout_ctrl;

  localparam int E = 5;
  localparam int X = 10;
  localparam int S = 2;
  localparam int NPIX = 4;
  // Cycle offsets from the cycle start is driven, derived from phase lengths.
  localparam int T_EXPOSE  = 1 + E;
  localparam int T_CONVERT = T_EXPOSE + X;
  localparam int T_TURN    = T_CONVERT + 256;
  localparam int T_VALID   = T_TURN + 1 + S;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       erase, expose, ramp, read, data_oe, pix_valid, pix_ready, busy, frame_done;
  logic [1:0] pixel_addr, pix_addr;
  logic [7:0] data_out, data_in, pix_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } px_t;
  px_t exp_q[$];

  logic [7:0] codes[NPIX];
  logic [7:0] lat[NPIX];
  bit         clash = 1'b0;

  pixel_readout_ctrl #(
    .ROWS(2), .COLS(2), .ADDR_BITS(2),
    .ERASE_CYCLES(E), .EXPOSE_CYCLES(X), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .erase(erase), .expose(expose), .ramp(ramp), .read(read),
    .pixel_addr(pixel_addr), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .pix_data(pix_data), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pixel array model: erase presets, comparator flip latches the count.
  always @(posedge clk) begin
    for (int i = 0; i < NPIX; i++) begin
      if (erase) lat[i] <= 8'hEE;
      else if (data_oe && data_out == codes[i]) lat[i] <= data_out;
    end
  end

  // Addressed pixel drives DATA while read is high.
  assign data_in = read ? lat[pixel_addr] : 8'h00;

  // Sticky flag for both sides driving DATA at once.
  always @(posedge clk) if (data_oe && read) clash <= 1'b1;

  // Load codes, queue the expected readout and pulse start for one cycle.
  task automatic start_frame(input logic [7:0] c0, c1, c2, c3);
    px_t e;
    codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
    for (int i = 0; i < NPIX; i++) begin
      e.a = 2'(i);
      e.d = codes[i];
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle-by-cycle check of erase/expose/convert/turn/settle against timing.
  task automatic check_phases(input bit poke_expose);
    logic [17:0] got, want;
    logic        w_er, w_ex, w_cv, w_rd;
    logic [7:0]  w_do;
    for (int t = 1; t < T_VALID; t++) begin
      w_er = (t >= 1) && (t < T_EXPOSE);
      w_ex = (t >= T_EXPOSE) && (t < T_CONVERT);
      w_cv = (t >= T_CONVERT) && (t < T_TURN);
      w_rd = (t > T_TURN);
      w_do = w_cv ? 8'(t - T_CONVERT) : 8'h00;
      want = {w_er, w_ex, w_cv, w_cv, w_rd, 1'b1, 1'b0, 1'b0, 2'b00, w_do};
      got  = {erase, expose, ramp, data_oe, read, busy, pix_valid, frame_done, pixel_addr, data_out};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL phase t=%0d got=%h want=%h", t, got, want);
      end
      start = poke_expose && (t == T_EXPOSE + 3);
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (pix_valid !== 1'b1 || pix_addr !== 2'd0) begin
      fails++;
      $display("FAIL first_valid_latency pix_valid=%b pix_addr=%0d want 1/0", pix_valid, pix_addr);
    end
  endtask

  // Drain one frame's readout; optional stall and start poke on one pixel.
  task automatic read_frame(input int stall_addr, input int stall_cycles, input bit poke_hold);
    int         stalls_left = 0;
    int         since_accept = 0;
    int         accepts = 0;
    bit         new_pixel = 1'b1;
    bit         have_accept = 1'b0;
    bit         finished = 1'b0;
    logic [7:0] snap_d = '0;
    logic [1:0] snap_a = '0;
    px_t        e;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      start = 1'b0;
      if (frame_done === 1'b1) begin
        tests++;
        if (exp_q.size() != 0 || busy !== 1'b0 || pix_valid !== 1'b0 || accepts != NPIX) begin
          fails++;
          $display("FAIL frame_done_state left=%0d busy=%b valid=%b accepts=%0d want 0/0/0/%0d",
                   exp_q.size(), busy, pix_valid, accepts, NPIX);
        end
        finished = 1'b1;
      end else if (pix_valid === 1'b1) begin
        if (new_pixel) begin
          snap_d = pix_data;
          snap_a = pix_addr;
          stalls_left = (int'(pix_addr) == stall_addr) ? stall_cycles : 0;
          new_pixel = 1'b0;
          if (have_accept) begin
            tests++;
            if (since_accept != S + 1) begin
              fails++;
              $display("FAIL pixel_period got=%0d want=%0d", since_accept, S + 1);
            end
          end
        end else begin
          tests++;
          if (pix_data !== snap_d || pix_addr !== snap_a || pixel_addr !== snap_a) begin
            fails++;
            $display("FAIL hold_stable data=%h addr=%0d pixel_addr=%0d want %h/%0d",
                     pix_data, pix_addr, pixel_addr, snap_d, snap_a);
          end
        end
        if (stalls_left > 0) begin
          pix_ready = 1'b0;
          start = poke_hold && (stalls_left == 3);
          stalls_left--;
        end else begin
          pix_ready = 1'b1;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pixel addr=%0d data=%h", pix_addr, pix_data);
          end else begin
            e = exp_q.pop_front();
            if (pix_addr !== e.a || pix_data !== e.d) begin
              fails++;
              $display("FAIL pixel addr=%0d data=%0d want addr=%0d data=%0d",
                       pix_addr, pix_data, e.a, e.d);
            end
          end
          accepts++;
          new_pixel = 1'b1;
          have_accept = 1'b1;
          since_accept = 0;
        end
      end else begin
        pix_ready = 1'b0;
        if (!new_pixel) begin
          tests++;
          fails++;
          $display("FAIL valid_dropped addr=%0d without accept", snap_a);
          new_pixel = 1'b1;
        end
      end
      if (!finished) begin
        @(negedge clk);
        since_accept++;
      end
    end
    pix_ready = 1'b0;
    if (!finished) begin
      tests++;
      fails++;
      $display("FAIL frame_done_timeout got=0 want=1");
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({erase, expose, ramp, read, data_oe, pix_valid, busy, frame_done} !== 8'h00 ||
        pixel_addr !== 2'd0 || data_out !== 8'd0 || pix_data !== 8'd0 || pix_addr !== 2'd0) begin
      fails++;
      $display("FAIL reset_state ctl=%b data_out=%h pix=%h want all 0",
               {erase, expose, ramp, read, data_oe, pix_valid, busy, frame_done}, data_out, pix_data);
    end
  endtask

  // Phase lengths plus readout ordering with codes 10/20/30/40.
  task automatic test_phase_lengths;
    start_frame(8'd10, 8'd20, 8'd30, 8'd40);
    check_phases(1'b0);
    read_frame(-1, 0, 1'b0);
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_done_pulse frame_done=%b busy=%b want 0/0", frame_done, busy);
    end
  endtask

  // Stall pixel 1 for 7 cycles; poke start in EXPOSE and READ_HOLD; edge codes.
  task automatic test_backpressure_busy_start;
    start_frame(8'd0, 8'd255, 8'd128, 8'd77);
    check_phases(1'b1);
    read_frame(1, 7, 1'b1);
  endtask

  // Start during the frame_done cycle must launch ERASE on the next edge.
  task automatic test_back_to_back;
    start_frame(8'd3, 8'd2, 8'd1, 8'd200);
    tests++;
    if (erase !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back erase=%b busy=%b frame_done=%b want 1/1/0", erase, busy, frame_done);
    end
    check_phases(1'b0);
    read_frame(-1, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_convert;
    bit hit = 1'b0;
    start_frame(8'd50, 8'd150, 8'd99, 8'd101);
    for (int i = 0; i < 400 && !hit; i++) begin
      if (data_oe === 1'b1 && data_out === 8'd100) hit = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reach_count_100 got=%0d want=100", data_out);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (data_oe !== 1'b0 || ramp !== 1'b0 || busy !== 1'b0 || data_out !== 8'd0) begin
      fails++;
      $display("FAIL async_reset oe=%b ramp=%b busy=%b data_out=%h want 0/0/0/00",
               data_oe, ramp, busy, data_out);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL no_frame_after_reset frame_done=%b busy=%b want 0/0", frame_done, busy);
      end
    end
    start_frame(8'd60, 8'd61, 8'd62, 8'd63);
    check_phases(1'b0);
    read_frame(-1, 0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) codes[i] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_phase_lengths();
    test_backpressure_busy_start();
    test_back_to_back();
    test_reset_mid_convert();
    tests++;
    if (clash) begin
      fails++;
      $display("FAIL bus_clash got=1 want=0");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
